// File: rtl/rob_commit_queue_pkg.sv
// rtl/rob_commit_queue_pkg.sv - shared types and constants for the reorder/commit queue
package rob_commit_queue_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;
  typedef logic [ROB_IDX_W:0]   rob_ptr_t;

  localparam logic [4:0] EXC_NONE = 5'd0;

  typedef struct packed {
    logic        done;
    logic [4:0]  excode;
    logic [31:0] pc;
    logic        is_store;
    logic [5:0]  phy_dest;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit_queue_ptr_ctr.sv
// rtl/rob_commit_queue_ptr_ctr.sv - wrap-bit queue pointer, step 0/1/2, synchronous clear
module rob_ptr_ctr #(
  parameter int PTR_W = 5
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic [1:0]       inc_i,
  output logic [PTR_W-1:0] ptr_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Top bit is the wrap bit; it toggles naturally on overflow of the index bits.
  always_comb begin
    ptr_d = clr_i ? '0 : ptr_q + PTR_W'(inc_i);
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/rob_commit_queue.sv
// rtl/rob_commit_queue.sv - in-order reorder/commit queue; perf counters under ROB_COMMIT_PERF_EN
module rob_commit_queue
  import rob_commit_queue_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic [1:0]            alloc_valid,
  input  logic [1:0][31:0]      alloc_pc,
  input  logic [1:0]            alloc_is_store,
  input  logic [1:0][5:0]       alloc_phy_dest,
  output logic                  alloc_ready,
  output logic [1:0][IDX_W-1:0] alloc_idx,
  input  logic [2:0]            wb_valid,
  input  logic [2:0][IDX_W-1:0] wb_idx,
  input  logic [2:0][4:0]       wb_excode,
  output logic [1:0]            commit_valid,
  output logic [1:0][31:0]      commit_pc,
  output logic [1:0][5:0]       commit_phy_dest,
  output logic [4:0]            commit_excode,
  output logic                  commit_store1_valid,
  output logic                  commit_store2_valid,
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_full_stall
);

  localparam int PTR_W = IDX_W + 1;

  logic             clr;
  logic [PTR_W-1:0] head_ptr, tail_ptr;
  logic [IDX_W-1:0] head_idx, head1_idx, tail_idx;
  logic [PTR_W-1:0] count_q, count_d;
  rob_entry_t       ent_q [DEPTH];
  rob_entry_t       ent_d [DEPTH];
  rob_entry_t       head_e, next_e;
  logic             empty, full, alloc_fire;
  logic [1:0]       n_alloc, n_retire;
  logic [2:0]       wb_hit;

  assign clr       = reset | flush;
  assign head_idx  = head_ptr[IDX_W-1:0];
  assign head1_idx = head_idx + IDX_W'(1);
  assign tail_idx  = tail_ptr[IDX_W-1:0];
  assign empty     = (head_ptr == tail_ptr);
  assign full      = (head_ptr[IDX_W] != tail_ptr[IDX_W]) && (head_idx == tail_idx);

  // Allocation is all-or-nothing: two free slots are always required.
  assign alloc_ready  = (PTR_W'(DEPTH) - count_q) >= PTR_W'(2);
  assign alloc_idx[0] = tail_idx;
  assign alloc_idx[1] = tail_idx + IDX_W'(1);
  assign alloc_fire   = alloc_ready && alloc_valid[0] && !clr;
  assign n_alloc      = !alloc_fire ? 2'd0 : (alloc_valid[1] ? 2'd2 : 2'd1);

  rob_ptr_ctr #(.PTR_W(PTR_W)) u_head (
    .clk   (clk),
    .clr_i (clr),
    .inc_i (n_retire),
    .ptr_o (head_ptr)
  );

  rob_ptr_ctr #(.PTR_W(PTR_W)) u_tail (
    .clk   (clk),
    .clr_i (clr),
    .inc_i (n_alloc),
    .ptr_o (tail_ptr)
  );

  // Retire selection from registered state; faulting entries retire alone in slot 0.
  always_comb begin
    head_e       = ent_q[head_idx];
    next_e       = ent_q[head1_idx];
    commit_valid = 2'b00;
    if (!clr && !empty && head_e.done) begin
      commit_valid[0] = 1'b1;
      if (head_e.excode == EXC_NONE && count_q >= PTR_W'(2) &&
          next_e.done && next_e.excode == EXC_NONE) begin
        commit_valid[1] = 1'b1;
      end
    end
    n_retire = {1'b0, commit_valid[0]} + {1'b0, commit_valid[1]};
  end

  // Commit payloads are zero whenever the slot is not retiring.
  always_comb begin
    commit_pc[0]        = commit_valid[0] ? head_e.pc : 32'd0;
    commit_pc[1]        = commit_valid[1] ? next_e.pc : 32'd0;
    commit_phy_dest[0]  = commit_valid[0] ? head_e.phy_dest : 6'd0;
    commit_phy_dest[1]  = commit_valid[1] ? next_e.phy_dest : 6'd0;
    commit_excode       = commit_valid[0] ? head_e.excode : EXC_NONE;
    commit_store1_valid = commit_valid[0] && head_e.is_store && head_e.excode == EXC_NONE;
    commit_store2_valid = commit_valid[1] && next_e.is_store;
  end

  // A writeback counts only if its index lies in the live window [head, tail).
  always_comb begin
    for (int b = 0; b < 3; b++) begin
      wb_hit[b] = wb_valid[b] && ({1'b0, wb_idx[b] - head_idx} < count_q);
    end
  end

  // Entry next-state: flush clears done, else writeback then allocation.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (clr) begin
        ent_d[i].done = 1'b0;
      end else begin
        for (int b = 0; b < 3; b++) begin
          if (wb_hit[b] && wb_idx[b] == IDX_W'(i)) begin
            ent_d[i].done   = 1'b1;
            ent_d[i].excode = wb_excode[b];
          end
        end
        for (int k = 0; k < 2; k++) begin
          if (alloc_fire && alloc_valid[k] && alloc_idx[k] == IDX_W'(i)) begin
            ent_d[i].done     = 1'b0;
            ent_d[i].excode   = EXC_NONE;
            ent_d[i].pc       = alloc_pc[k];
            ent_d[i].is_store = alloc_is_store[k];
            ent_d[i].phy_dest = alloc_phy_dest[k];
          end
        end
      end
    end
    count_d = clr ? '0 : count_q + PTR_W'(n_alloc) - PTR_W'(n_retire);
  end

  // Entry storage and occupancy register.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_q[i] <= ent_d[i];
    end
    count_q <= count_d;
  end

`ifdef ROB_COMMIT_PERF_EN
  logic [31:0] perf_retired_q, perf_full_stall_q;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_retired_q    <= 32'd0;
      perf_full_stall_q <= 32'd0;
    end else begin
      perf_retired_q <= perf_retired_q + 32'(n_retire);
      if (alloc_valid[0] && !alloc_ready) begin
        perf_full_stall_q <= perf_full_stall_q + 32'd1;
      end
    end
  end

  assign perf_retired    = perf_retired_q;
  assign perf_full_stall = perf_full_stall_q;
`else
  assign perf_retired    = 32'd0;
  assign perf_full_stall = 32'd0;
`endif

  wb_unique_a: assert property (@(posedge clk) disable iff (reset)
    !((wb_valid[0] && wb_valid[1] && wb_idx[0] == wb_idx[1]) ||
      (wb_valid[0] && wb_valid[2] && wb_idx[0] == wb_idx[2]) ||
      (wb_valid[1] && wb_valid[2] && wb_idx[1] == wb_idx[2])));

  full_count_a: assert property (@(posedge clk) disable iff (reset)
    full == (count_q == PTR_W'(DEPTH)));

endmodule

// File: doc/rob_commit_queue.md
Name: rob_commit_queue

Overview:
- In-order reorder/commit queue directly downstream of the execute stage.
- Dispatch allocates up to 2 entries/cycle in program order. The three execute writeback buses (ALU1/BRU/MDU, ALU2/SPU/MDU, AGU) mark entries complete.
- Retires up to 2 completed entries/cycle in order and drives commit_store1/2_valid back to the AGU.
- Exceptions retire alone; the commit controller then raises flush.

Parameters:
- DEPTH, 16, number of entries; power of two, >= 4.
- IDX_W, $clog2(DEPTH), entry index width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; empties queue
- alloc_valid  in  2  allocation request per slot; [1] only with [0]
- alloc_pc  in  2x32  PC per slot
- alloc_is_store  in  2  slot is a store
- alloc_phy_dest  in  2x6  physical destination (0 = none)
- alloc_ready  out  1  at least 2 free entries
- alloc_idx  out  2xIDX_W  indices that would be assigned (tail, tail+1)
- wb_valid  in  3  writeback valid, buses 1..3
- wb_idx  in  3xIDX_W  entry index per bus
- wb_excode  in  3x5  exception code, 0 = none
- commit_valid  out  2  retiring this cycle, per slot
- commit_pc  out  2x32  PC of retiring entry
- commit_phy_dest  out  2x6  destination of retiring entry
- commit_excode  out  5  excode of slot 0
- commit_store1_valid  out  1  slot 0 retiring a store
- commit_store2_valid  out  1  slot 1 retiring a store
- perf_retired  out  32  retired count (see Optional Feature)
- perf_full_stall  out  32  full-stall cycles (see Optional Feature)

Behaviour:
- State: head/tail pointers of IDX_W+1 bits (wrap bit), count 0..DEPTH, per-entry done/excode/pc/is_store/phy_dest.
- Full when head and tail differ only in the wrap bit. Empty when head == tail.
- alloc_ready = (DEPTH - count) >= 2, registered-state combinational. Allocation is all-or-nothing: fires only when alloc_ready. Slot k is written at tail+k with done cleared. Tail advances by popcount(alloc_valid).
- Writeback: wb_valid[i] sets done and stores excode at wb_idx[i] on the next edge. No same-cycle bypass: retire sees the entry done one cycle later.
  - Two buses writing the same idx in one cycle is illegal (assertion).
  - Writeback to an unallocated entry is ignored.
- Retire (combinational from registered state):
  - commit_valid[0] = !empty && done[head].
  - commit_valid[1] = commit_valid[0] && excode[head]==0 && count>=2 && done[head+1] && excode[head+1]==0.
  - An entry with nonzero excode only ever retires in slot 0, alone.
- Head advances by popcount(commit_valid). count updates as count + allocs - retires; simultaneous alloc and retire is legal at full and empty boundaries.
- Store outputs: commit_store1_valid = commit_valid[0] && is_store[head] && excode==0. commit_store2_valid is the same for slot 1.
- Wrap-around: index = pointer[IDX_W-1:0]; the wrap bit toggles on overflow.
- flush (same cycle): all commit outputs forced 0. Next edge: head=tail=0, count=0, all done cleared. Allocation and writeback in the flush cycle are discarded.
- reset: identical to flush. After reset: alloc_ready=1, commit_valid=0, store valids 0, perf counters 0.

Optional Feature:
- Macro ROB_COMMIT_PERF_EN.
- Defined: perf_retired accumulates popcount(commit_valid) each cycle. perf_full_stall increments when alloc_valid[0] && !alloc_ready. Both wrap at 2^32 and are cleared by reset only, not flush.
- Undefined: both ports tied to 0 and no counter flops exist.

Decomposition:
- Shared cpu package gets: ROB_DEPTH, rob_idx_t, rob_ptr_t (IDX_W+1 bits), EXC_NONE=5'd0, and a rob_entry_t struct {done, excode, pc, is_store, phy_dest}.
- One sub-module: rob_ptr_ctr, a wrap-bit pointer with increment-by-0/1/2 and synchronous clear. Instantiated for head and tail.

Test Plan:
- Reset, then alloc 2 (pc 0x100, 0x104), wb both next cycle -> commit_valid=2'b11 exactly one cycle after wb; pcs 0x100/0x104; count returns to 0.
- Writeback out of order (idx1 before idx0) -> no commit until idx0 done; then both retire in the same cycle.
- idx0 wb excode=5'd4, idx1 clean -> only commit_valid[0]=1, commit_excode=4, store valids 0; flush next cycle -> empty, alloc_ready=1.
- Fill DEPTH=16 entries -> alloc_ready=0 at count 15 and 16. Simultaneous retire of 2 plus alloc of 2 at count 14 -> count stays 14. Tail wraps and the wrap bit toggles.
- Two adjacent stores both done -> commit_store1_valid=commit_store2_valid=1 in the same cycle. A store with excode -> no store valid.
- With ROB_COMMIT_PERF_EN: 10 retires and 3 cycles of alloc blocked while full -> perf_retired=10, perf_full_stall=3; values unchanged by flush.
